fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that produces the 16-bit instruction word consumed by the control decoder and responds to its outcomes: redirect (jump/branch) and halt. It owns the PC and drives a request/acknowledge instruction-memory interface. It also presents each fetched word, with its PC, to decode through a valid/ready handshake. It sits between instruction memory and the `control`/register-file decode stage.

## Interface
- `PC_W`, 16: PC and address width.
- `RESET_PC`, 16'h0000: PC loaded on reset.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `imem_req` output 1: fetch request; address held stable while high.
- `imem_addr` output PC_W: fetch address.
- `imem_ack` input 1: memory completes the current request this cycle.
- `imem_rdata` input 16: instruction word, valid when `imem_ack`.
- `instr` output 16: instruction to decode; `instr[15:11]` drives the decoder's Instr input and `instr[1:0]` drives its OpCode input.
- `instr_pc` output PC_W: address of `instr`.
- `pc_inc` output PC_W: `instr_pc + 2`, modulo 2^PC_W.
- `instr_valid` output 1: `instr` is presented.
- `instr_ready` input 1: decode accepts `instr` this cycle.
- `redirect` input 1: decode has taken a jump or branch.
- `redirect_pc` input PC_W: redirect target.
- `halt` input 1: the decoded instruction is HALT. Only qualified when an instruction is accepted.
- `halted` output 1: fetch is permanently stopped.
- `err` output 1: misaligned redirect detected (see Configuration).

## Operation
- The accept condition is `instr_valid & instr_ready`.
- State IDLE:
  - `imem_req` = 0.
  - Goes to REQ on the next cycle.
- State REQ:
  - `imem_req` = 1 and `imem_addr` = pc.
  - On `imem_ack`: capture `imem_rdata` into `instr` and pc into `instr_pc`, then go to HOLD.
  - On `redirect` without `imem_ack`: pc <= target, go to DRAIN.
  - On `redirect` with `imem_ack`: discard the data, pc <= target, go to REQ.
- State DRAIN:
  - `imem_req` = 1 with the old address held.
  - On `imem_ack`: discard the data and go to REQ at the new pc.
  - A further `redirect` in DRAIN only updates pc.
- State HOLD:
  - `instr_valid` = 1.
  - On accept with `halt`: go to HALTED.
  - On accept without redirect: pc <= `instr_pc + 2`, go to REQ.
  - On `redirect` (accepted or not): pc <= target, `instr_valid` drops, go to REQ.
- State HALTED:
  - `imem_req` = 0, `instr_valid` = 0, `halted` = 1.
  - Exits only on `rst`.
- Priority: `rst` > halt-on-accept > `redirect` > sequential increment.
- `halt` is ignored outside HOLD, and ignored when not accepted.
- Reset values:
  - state IDLE, pc = `RESET_PC`.
  - `imem_req` = 0, `imem_addr` = `RESET_PC`.
  - `instr` = 16'h0800 (NOP), `instr_pc` = `RESET_PC`, `instr_valid` = 0.
  - `halted` = 0, `err` = 0.
- Reset asserted in any state, including with a request outstanding, abandons all activity. Any late `imem_ack` arriving while in IDLE is ignored.
- PC arithmetic wraps: 16'hFFFE + 2 = 16'h0000.

## Timing
- Fetch latency: request issued 1 cycle after IDLE. With `imem_ack` in the same cycle as `imem_req`, `instr_valid` rises on the next cycle.
- Best-case throughput: one instruction per 2 cycles (REQ, HOLD).
- Redirect penalty:
  - From HOLD or REQ-with-ack: the next request is to the target on the next cycle.
  - From DRAIN: the request to the target starts 1 cycle after the old ack.
- `instr`, `instr_pc` and `instr_valid` are registered. `imem_req` and `imem_addr` decode from registered state and pc. `pc_inc` is combinational from `instr_pc`.
- `instr` is stable while `instr_valid` = 1 and not accepted.

## Configuration
- Macro: `FETCH_ALIGN_CHK_EN`.
- Defined:
  - A redirect with `redirect_pc[0]` = 1 sets `err` = 1 and goes to HALTED on the next cycle. No request is issued to the target.
  - `err` stays 1 until `rst`.
  - This check has priority over normal redirect handling. Halt-on-accept still wins.
- Undefined:
  - The target LSB is forced to 0 (pc <= {`redirect_pc[PC_W-1:1]`, 1'b0}).
  - `err` is tied to 0.

## Test plan
- Sequential fetch:
  - Stimulus: reset, memory acks the same cycle, `instr_ready` = 1, memory returns words A, B, C.
  - Response: `instr_pc` reads 0x0000, 0x0002, 0x0004 on consecutive HOLD cycles; `pc_inc` = `instr_pc + 2`.
- Backpressure:
  - Stimulus: `instr_ready` = 0 for 5 cycles in HOLD.
  - Response: `instr`/`instr_pc` unchanged and `imem_req` = 0 throughout; the next request goes to 0x0002 after acceptance.
- Redirect during REQ, ack delayed 3 cycles:
  - Stimulus: `redirect_pc` = 0x0040.
  - Response: the old address is held until ack, the data is discarded, then `imem_addr` = 0x0040. No `instr_valid` appears with the stale data.
- Halt:
  - Stimulus: accepted instruction with `halt` = 1 and `redirect` = 1.
  - Response: `halted` = 1 next cycle, `imem_req` stays 0 for 20 cycles, and `rst` restores fetching from `RESET_PC`.
- Wrap and alignment:
  - Stimulus: redirect to 0xFFFE, then sequential fetch; separately, redirect to 0x0031.
  - Response: the sequential fetch after 0xFFFE goes to 0x0000.
  - Response with the macro defined: 0x0031 gives `err` = 1 and `halted` = 1.
  - Response without the macro: 0x0031 gives a fetch at 0x0030 and `err` = 0.
- Mid-fetch reset:
  - Stimulus: `rst` asserted while in DRAIN, then a late `imem_ack`.
  - Response: state IDLE, the late ack is ignored, and the first request after reset is to `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues req/ack fetches to imem, hands words + PC to decode.
// Latency: request 1 cycle after IDLE; instr_valid the cycle after imem_ack. Best case 1 instr / 2 cycles.
// Backpressure: HOLD keeps instr/instr_pc stable and suppresses imem_req until instr_ready.
//
// Ports: clk/rst (sync, active-high); imem_req/imem_addr/imem_ack/imem_rdata go to instruction memory;
//        instr/instr_pc/pc_inc/instr_valid/instr_ready go to decode; redirect/redirect_pc/halt come from decode;
//        halted/err report status.
// Optional feature: define FETCH_ALIGN_CHK_EN to flag misaligned redirects (err + halt) instead of
// silently clearing the target LSB.
module fetch_unit #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     instr,
    output logic [PC_W-1:0] instr_pc,
    output logic [PC_W-1:0] pc_inc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            halt,
    output logic            halted,
    output logic            err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN,
        S_HOLD,
        S_HALTED
    } state_t;

    localparam logic [15:0] NOP_INSTR = 16'h0800;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    // Address of the abandoned request; must stay on the bus until its ack arrives.
    logic [PC_W-1:0] drain_addr_q, drain_addr_d;
    logic [15:0]     instr_q, instr_d;
    logic [PC_W-1:0] instr_pc_q, instr_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic            halted_q, halted_d;
    logic            err_q, err_d;

    logic            accept;
    logic [PC_W-1:0] redirect_tgt;
    logic            misalign;

    assign accept = instr_valid_q & instr_ready;

`ifdef FETCH_ALIGN_CHK_EN
    assign redirect_tgt = redirect_pc;
    assign misalign     = redirect & redirect_pc[0];
`else
    // Odd targets are rounded down to the halfword boundary.
    assign redirect_tgt = redirect_pc & ~PC_W'(1);
    assign misalign     = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drain_addr_d  = drain_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        err_d         = err_q;

        case (state_q)
            S_IDLE: begin
                // A late ack from before reset lands here and is dropped.
                state_d = S_REQ;
            end
            S_REQ: begin
                if (misalign) begin
                    err_d         = 1'b1;
                    halted_d      = 1'b1;
                    instr_valid_d = 1'b0;
                    state_d       = S_HALTED;
                end else if (redirect) begin
                    pc_d = redirect_tgt;
                    if (imem_ack) begin
                        // Returned word is stale; refetch at the target right away.
                        state_d = S_REQ;
                    end else begin
                        drain_addr_d = pc_q;
                        state_d      = S_DRAIN;
                    end
                end else if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = S_HOLD;
                end
            end
            S_DRAIN: begin
                if (misalign) begin
                    err_d         = 1'b1;
                    halted_d      = 1'b1;
                    instr_valid_d = 1'b0;
                    state_d       = S_HALTED;
                end else begin
                    if (redirect) begin
                        pc_d = redirect_tgt;
                    end
                    if (imem_ack) begin
                        state_d = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (accept && halt) begin
                    halted_d      = 1'b1;
                    instr_valid_d = 1'b0;
                    state_d       = S_HALTED;
                end else if (misalign) begin
                    err_d         = 1'b1;
                    halted_d      = 1'b1;
                    instr_valid_d = 1'b0;
                    state_d       = S_HALTED;
                end else if (redirect) begin
                    pc_d          = redirect_tgt;
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
                end else if (accept) begin
                    pc_d          = instr_pc_q + PC_W'(2);
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            drain_addr_q  <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drain_addr_q  <= drain_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            err_q         <= err_d;
        end
    end

    assign imem_req    = (state_q == S_REQ) || (state_q == S_DRAIN);
    assign imem_addr   = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc_inc      = instr_pc_q + PC_W'(2);
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] pc_inc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        halted;
    logic        err;

    fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .pc_inc      (pc_inc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .halted      (halted),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] word;
    } exp_t;

    exp_t sb_q[$];
    int   total_cnt = 0;
    int   fail_cnt  = 0;

    // Memory model controls (written only by the main sequence).
    int   ack_delay = 0;
    logic mem_en    = 1'b1;
    logic force_ack = 1'b0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // Memory responder: evaluates shortly after each rising edge so ack is settled well before the next one.
    initial begin
        int cnt;
        cnt        = 0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #2;
            if (force_ack) begin
                imem_ack   = 1'b1;
                imem_rdata = 16'hDEAD;
            end else if (mem_en && imem_req) begin
                if (cnt >= ack_delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    cnt        = 0;
                end else begin
                    imem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                cnt      = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] pc);
        exp_t e;
        e.pc   = pc;
        e.word = mem_word(pc);
        sb_q.push_back(e);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!instr_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid_timeout"}, 32'(n < 50), 32'd1);
    endtask

    task automatic wait_accept(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!(instr_valid && instr_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept_timeout"}, 32'(n < 50), 32'd1);
        if (n < 50) begin
            chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk({tag, "_instr"}, 32'(instr), 32'(e.word));
                chk({tag, "_instr_pc"}, 32'(instr_pc), 32'(e.pc));
                chk({tag, "_pc_inc"}, 32'(pc_inc), 32'(16'(e.pc + 16'd2)));
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int req_cycles;
        rst         = 1'b1;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        halt        = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'h0000);
        chk("rst_instr", 32'(instr), 32'h0800);
        chk("rst_instr_pc", 32'(instr_pc), 32'h0000);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Sequential fetch, same-cycle ack
        rst         = 1'b0;
        instr_ready = 1'b1;
        push_exp(16'h0000);
        push_exp(16'h0002);
        push_exp(16'h0004);
        wait_accept("seq0");
        wait_accept("seq1");
        wait_accept("seq2");

        // Backpressure in HOLD for 5 cycles
        instr_ready = 1'b0;
        wait_valid("bp");
        for (int i = 0; i < 5; i++) begin
            chk("bp_instr", 32'(instr), 32'(mem_word(16'h0006)));
            chk("bp_instr_pc", 32'(instr_pc), 32'h0006);
            chk("bp_imem_req", 32'(imem_req), 32'd0);
            @(negedge clk);
        end
        ack_delay   = 3;
        instr_ready = 1'b1;
        push_exp(16'h0006);
        wait_accept("bp_rel");
        chk("bp_next_req", 32'(imem_req), 32'd1);
        chk("bp_next_addr", 32'(imem_addr), 32'h0008);

        // Redirect during REQ with slow ack: old address held, data discarded
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        @(negedge clk);
        redirect = 1'b0;
        chk("drain_addr_held", 32'(imem_addr), 32'h0008);
        n = 0;
        while (!(imem_req && imem_addr == 16'h0040) && n < 20) begin
            chk("drain_no_stale_valid", 32'(instr_valid), 32'd0);
            @(negedge clk);
            n++;
        end
        chk("drain_req_timeout", 32'(n < 20), 32'd1);
        chk("drain_new_addr", 32'(imem_addr), 32'h0040);
        chk("drain_new_valid", 32'(instr_valid), 32'd0);
        instr_ready = 1'b1;
        push_exp(16'h0040);
        wait_accept("redir40");
        ack_delay = 0;

        // Redirect from HOLD to 0xFFFE, then wrap to 0x0000
        instr_ready = 1'b0;
        wait_valid("wrap");
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        @(negedge clk);
        redirect = 1'b0;
        chk("wrap_req", 32'(imem_req), 32'd1);
        chk("wrap_addr", 32'(imem_addr), 32'hFFFE);
        chk("wrap_valid_drop", 32'(instr_valid), 32'd0);
        sb_q.delete();
        instr_ready = 1'b1;
        push_exp(16'hFFFE);
        push_exp(16'h0000);
        wait_accept("wrap_fffe");
        wait_accept("wrap_0000");

        // Misaligned redirect
        instr_ready = 1'b0;
        wait_valid("align");
        redirect    = 1'b1;
        redirect_pc = 16'h0031;
        @(negedge clk);
        redirect = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        chk("align_err", 32'(err), 32'd1);
        chk("align_halted", 32'(halted), 32'd1);
        chk("align_no_req", 32'(imem_req), 32'd0);
`else
        chk("align_addr", 32'(imem_addr), 32'h0030);
        chk("align_req", 32'(imem_req), 32'd1);
        chk("align_err", 32'(err), 32'd0);
        instr_ready = 1'b1;
        push_exp(16'h0030);
        wait_accept("align_fetch");
`endif

        // Halt wins over redirect on accept
        sb_q.delete();
        instr_ready = 1'b0;
        do_reset();
        wait_valid("halt");
        instr_ready = 1'b1;
        halt        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        @(negedge clk);
        halt     = 1'b0;
        redirect = 1'b0;
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_valid", 32'(instr_valid), 32'd0);
        chk("halt_err", 32'(err), 32'd0);
        req_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) req_cycles++;
            @(negedge clk);
        end
        chk("halt_req_quiet", 32'(req_cycles), 32'd0);
        chk("halt_sticky", 32'(halted), 32'd1);

        // Reset restores fetching; then push into DRAIN and reset mid-fetch
        instr_ready = 1'b0;
        ack_delay   = 10;
        do_reset();
        chk("post_halt_rst_halted", 32'(halted), 32'd0);
        n = 0;
        while (!imem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("post_halt_req_timeout", 32'(n < 10), 32'd1);
        chk("post_halt_addr", 32'(imem_addr), 32'h0000);
        redirect    = 1'b1;
        redirect_pc = 16'h0080;
        @(negedge clk);
        redirect = 1'b0;
        chk("mid_drain_req", 32'(imem_req), 32'd1);
        chk("mid_drain_addr", 32'(imem_addr), 32'h0000);
        rst    = 1'b1;
        mem_en = 1'b0;
        @(negedge clk);
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_addr", 32'(imem_addr), 32'h0000);
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        force_ack = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        force_ack = 1'b0;
        mem_en    = 1'b1;
        ack_delay = 0;
        @(negedge clk);
        chk("mid_first_req", 32'(imem_req), 32'd1);
        chk("mid_first_addr", 32'(imem_addr), 32'h0000);
        chk("mid_late_ack_ignored", 32'(instr_valid), 32'd0);
        instr_ready = 1'b1;
        push_exp(16'h0000);
        wait_accept("mid_fetch");

        $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
        $finish;
    end

endmodule
